// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared constants for the execute stage that sits behind the 16x16 register
// file: opcodes, instruction field positions, flag bit indices and the
// sequencer state encoding.
// Configuration macro: ALU_MUL_EN adds the MUL state (opcode 0xB).
// ---------------------------------------------------------------------------
package alu_pkg;

   // Opcodes (instr[15:12])
   localparam logic [3:0] OP_ADD = 4'h0;
   localparam logic [3:0] OP_SUB = 4'h1;
   localparam logic [3:0] OP_AND = 4'h2;
   localparam logic [3:0] OP_OR  = 4'h3;
   localparam logic [3:0] OP_XOR = 4'h4;
   localparam logic [3:0] OP_NOT = 4'h5;
   localparam logic [3:0] OP_SHL = 4'h6;
   localparam logic [3:0] OP_SHR = 4'h7;
   localparam logic [3:0] OP_MOV = 4'h8;
   localparam logic [3:0] OP_CMP = 4'hA;
   localparam logic [3:0] OP_MUL = 4'hB;

   // Instruction field bit positions
   localparam int OP_HI = 15;
   localparam int OP_LO = 12;
   localparam int RD_HI = 11;
   localparam int RD_LO = 8;
   localparam int RA_HI = 7;
   localparam int RA_LO = 4;
   localparam int RB_HI = 3;
   localparam int RB_LO = 0;

   // Flag bit indices within {Z,N,C,V}
   localparam int FLG_Z = 3;
   localparam int FLG_N = 2;
   localparam int FLG_C = 1;
   localparam int FLG_V = 0;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_READ  = 3'd1,
      S_EXEC  = 3'd2,
      S_WRITE = 3'd3
`ifdef ALU_MUL_EN
      ,
      S_MUL   = 3'd4
`endif
   } state_e;

endpackage

// File: rtl/alu_core.sv
// ---------------------------------------------------------------------------
// alu_core
// Purely combinational ALU: result and {Z,N,C,V} from op, a and b.
// Ports:
//   op_i      opcode
//   a_i, b_i  operands
//   result_o  ALU result (CMP yields the difference)
//   flags_o   {Z,N,C,V}
//   legal_o   opcode is implemented here (MUL is iterated by the sequencer)
// ---------------------------------------------------------------------------
module alu_core
   import alu_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic [3:0]       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] result_o,
   output logic [3:0]       flags_o,
   output logic             legal_o
);

   logic [WIDTH:0] sum;
   logic           c;
   logic           v;

   always_comb begin
      result_o = '0;
      flags_o  = '0;
      legal_o  = 1'b1;
      sum      = '0;
      c        = 1'b0;
      v        = 1'b0;
      case (op_i)
         OP_ADD: begin
            sum      = {1'b0, a_i} + {1'b0, b_i};
            result_o = sum[WIDTH-1:0];
            c        = sum[WIDTH];
            v        = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (result_o[WIDTH-1] != a_i[WIDTH-1]);
         end
         OP_SUB, OP_CMP: begin
            // the extra top bit of the widened difference is the borrow
            sum      = {1'b0, a_i} - {1'b0, b_i};
            result_o = sum[WIDTH-1:0];
            c        = sum[WIDTH];
            v        = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (result_o[WIDTH-1] != a_i[WIDTH-1]);
         end
         OP_AND: result_o = a_i & b_i;
         OP_OR:  result_o = a_i | b_i;
         OP_XOR: result_o = a_i ^ b_i;
         OP_NOT: result_o = ~a_i;
         OP_SHL: begin
            result_o = {a_i[WIDTH-2:0], 1'b0};
            c        = a_i[WIDTH-1];
         end
         OP_SHR: begin
            result_o = {1'b0, a_i[WIDTH-1:1]};
            c        = a_i[0];
         end
         OP_MOV: result_o = a_i;
         default: legal_o = 1'b0;
      endcase
      flags_o[FLG_Z] = (result_o == '0);
      flags_o[FLG_N] = result_o[WIDTH-1];
      flags_o[FLG_C] = c;
      flags_o[FLG_V] = v;
   end

endmodule

// File: rtl/alu_exec_sequencer.sv
// ---------------------------------------------------------------------------
// alu_exec_sequencer
// Execute stage behind the 16x16 register file. Accepts one instruction per
// handshake, drives the read selects, consumes the registered operands,
// computes result/flags and writes back through WR/RegSelect/IN.
// One instruction in flight: IDLE -> READ -> EXEC -> (MUL) -> WRITE -> IDLE.
// Ports:
//   clock, reset          rising-edge clock, synchronous active-low reset
//   instr, instr_valid    instruction {op,rd,ra,rb} and its valid
//   instr_ready           high in IDLE only
//   opa, opb              register file OUTA/OUTB (registered by the file)
//   a_sel, b_sel          register file read selects (ra/rb of the latch)
//   wr, wr_sel, wr_data   register file write port
//   flags                 registered {Z,N,C,V}
//   done, illegal, busy   retire pulse, undefined-opcode pulse, not-IDLE
// Configuration macro: ALU_MUL_EN enables opcode 0xB (16-cycle shift-add MUL).
// ---------------------------------------------------------------------------
module alu_exec_sequencer
   import alu_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int SELW  = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [15:0]      instr,
   input  logic             instr_valid,
   output logic             instr_ready,
   input  logic [WIDTH-1:0] opa,
   input  logic [WIDTH-1:0] opb,
   output logic [SELW-1:0]  a_sel,
   output logic [SELW-1:0]  b_sel,
   output logic             wr,
   output logic [SELW-1:0]  wr_sel,
   output logic [WIDTH-1:0] wr_data,
   output logic [3:0]       flags,
   output logic             done,
   output logic             illegal,
   output logic             busy
);

   state_e           state_q, state_d;
   logic [15:0]      instr_q, instr_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [3:0]       flags_q, flags_d;

   logic [WIDTH-1:0] core_res;
   logic [3:0]       core_flags;
   logic             core_legal;
   logic             op_legal;
   logic             op_writes;
   logic [3:0]       op;

`ifdef ALU_MUL_EN
   logic [2*WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [3:0]         cnt_q, cnt_d;
`endif

   assign op = instr_q[OP_HI:OP_LO];

   alu_core #(.WIDTH(WIDTH)) u_core (
      .op_i     (op),
      .a_i      (opa),
      .b_i      (opb),
      .result_o (core_res),
      .flags_o  (core_flags),
      .legal_o  (core_legal)
   );

`ifdef ALU_MUL_EN
   assign op_legal = core_legal | (op == OP_MUL);
`else
   assign op_legal = core_legal;
`endif
   assign op_writes = op_legal && (op != OP_CMP);

   // Selects come straight from the latch, so they hold until the next accept.
   assign a_sel       = instr_q[RA_HI:RA_LO];
   assign b_sel       = instr_q[RB_HI:RB_LO];
   assign wr_sel      = instr_q[RD_HI:RD_LO];
   assign wr_data     = result_q;
   assign flags       = flags_q;
   assign instr_ready = (state_q == S_IDLE);
   assign busy        = (state_q != S_IDLE);

   always_comb begin
      state_d  = state_q;
      instr_d  = instr_q;
      result_d = result_q;
      flags_d  = flags_q;
      done     = 1'b0;
      wr       = 1'b0;
      illegal  = 1'b0;
`ifdef ALU_MUL_EN
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (instr_valid) begin
               instr_d = instr;
               state_d = S_READ;
            end
         end
         S_READ: state_d = S_EXEC;
         S_EXEC: begin
            state_d = S_WRITE;
`ifdef ALU_MUL_EN
            if (op == OP_MUL) begin
               state_d  = S_MUL;
               mcand_d  = {{WIDTH{1'b0}}, opa};
               mplier_d = opb;
               acc_d    = '0;
               cnt_d    = '0;
            end else
`endif
            // illegal opcodes leave result and flags untouched
            if (core_legal) begin
               result_d = core_res;
               flags_d  = core_flags;
            end
         end
`ifdef ALU_MUL_EN
         S_MUL: begin
            acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
               state_d        = S_WRITE;
               result_d       = acc_d[WIDTH-1:0];
               flags_d        = '0;
               flags_d[FLG_Z] = (acc_d[WIDTH-1:0] == '0);
               flags_d[FLG_N] = acc_d[WIDTH-1];
               flags_d[FLG_C] = |acc_d[2*WIDTH-1:WIDTH];
            end
         end
`endif
         S_WRITE: begin
            // gated by reset so an abandoned write never reaches the file
            done    = reset;
            wr      = reset && op_writes;
            illegal = reset && !op_legal;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         instr_q  <= '0;
         result_q <= '0;
         flags_q  <= '0;
`ifdef ALU_MUL_EN
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         instr_q  <= instr_d;
         result_q <= result_d;
         flags_q  <= flags_d;
`ifdef ALU_MUL_EN
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
`endif
      end
   end

endmodule

// File: tb/tb_alu_exec_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_exec_sequencer
// Bench for alu_exec_sequencer with a behavioural register file around it and
// an arithmetic reference model for results, flags, write enable and latency.
// Follows ALU_MUL_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_alu_exec_sequencer;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [15:0] instr = '0;
   logic        instr_valid = 1'b0;
   logic        instr_ready;
   logic [15:0] opa, opb;
   logic [3:0]  a_sel, b_sel, wr_sel;
   logic        wr, done, illegal, busy;
   logic [15:0] wr_data;
   logic [3:0]  flags;

   int checks = 0;
   int errors = 0;

   logic [15:0] rf [16];
   logic        ld_en = 1'b0;
   logic [3:0]  ld_idx = '0;
   logic [15:0] ld_val = '0;
   logic [15:0] exp_rf [16];
   logic [3:0]  exp_flags = '0;

   alu_exec_sequencer #(.WIDTH(16), .SELW(4)) dut (
      .clock(clock), .reset(reset), .instr(instr), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .opa(opa), .opb(opb), .a_sel(a_sel), .b_sel(b_sel),
      .wr(wr), .wr_sel(wr_sel), .wr_data(wr_data), .flags(flags), .done(done),
      .illegal(illegal), .busy(busy)
   );

   always #5 clock = ~clock;

   // Register file: registered read ports, write port driven by the DUT.
   always @(posedge clock) begin
      if (wr) rf[wr_sel] <= wr_data;
      if (ld_en) rf[ld_idx] <= ld_val;
      opa <= rf[a_sel];
      opb <= rf[b_sel];
   end

   function automatic void model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                 input logic [3:0] fin, output logic [15:0] res,
                                 output logic [3:0] fo, output bit wrt, output bit ill);
      longint unsigned ua, ub, full;
      longint sa, sb, sr;
      bit c, v;
      ua = a; ub = b; sa = longint'($signed(a)); sb = longint'($signed(b));
      full = 0; sr = 0; c = 0; v = 0; wrt = 1; ill = 0;
      case (op)
         4'h0: begin full = ua + ub; c = full > 65535; sr = sa + sb; v = (sr > 32767) || (sr < -32768); end
         4'h1, 4'hA: begin
            full = (ua - ub) & 64'hFFFF; c = ua < ub; sr = sa - sb;
            v = (sr > 32767) || (sr < -32768); wrt = (op == 4'h1);
         end
         4'h2: full = ua & ub;
         4'h3: full = ua | ub;
         4'h4: full = ua ^ ub;
         4'h5: full = ~ua & 64'hFFFF;
         4'h6: begin full = (ua * 2) & 64'hFFFF; c = ua >= 32768; end
         4'h7: begin full = ua / 2; c = (ua % 2) == 1; end
         4'h8: full = ua;
`ifdef ALU_MUL_EN
         4'hB: begin full = ua * ub; c = full >= 65536; end
`endif
         default: ill = 1;
      endcase
      res = 16'(full % 65536);
      if (ill) begin wrt = 0; fo = fin; end
      else fo = {res == 16'h0, res[15], c, v};
   endfunction

   task automatic load_reg(input int idx, input logic [15:0] val);
      ld_en = 1'b1; ld_idx = 4'(idx); ld_val = val;
      @(negedge clock);
      ld_en = 1'b0;
      exp_rf[idx] = val;
   endtask

   // Issues one instruction and records what the DUT did; starts and ends on a negedge.
   task automatic issue(input logic [15:0] ins, output int lat, output int wr_cnt, output int done_cnt,
                        output logic [3:0] wsel, output logic [15:0] wdata, output logic ill,
                        output logic [3:0] fl, output bit tmo);
      int w;
      lat = 0; wr_cnt = 0; done_cnt = 0; wsel = '0; wdata = '0; ill = 0; fl = '0; tmo = 0; w = 0;
      while (!instr_ready && w < 40) begin @(negedge clock); w++; end
      if (!instr_ready) begin tmo = 1; return; end
      instr = ins; instr_valid = 1'b1;
      @(negedge clock);
      instr_valid = 1'b0; instr = 16'($urandom);   // junk while busy must be ignored
      for (int n = 1; n <= 40; n++) begin
         if (n > 1) @(negedge clock);
         if (wr) begin wr_cnt++; wsel = wr_sel; wdata = wr_data; end
         if (done) begin done_cnt++; lat = n; ill = illegal; fl = flags; break; end
      end
      if (done_cnt == 0) begin tmo = 1; return; end
      @(negedge clock);
      if (done) done_cnt++;
      if (wr) wr_cnt++;
   endtask

   task automatic test_reset;
      reset = 1'b0; instr_valid = 1'b0;
      repeat (3) @(negedge clock);
      checks++; if ({instr_ready, busy, wr, done, illegal} !== 5'b10000) begin errors++;
         $display("FAIL reset_ctrl got %b want 10000", {instr_ready, busy, wr, done, illegal}); end
      checks++; if ({a_sel, b_sel, wr_sel} !== 12'h000) begin errors++;
         $display("FAIL reset_sels got %h want 000", {a_sel, b_sel, wr_sel}); end
      checks++; if (wr_data !== 16'h0) begin errors++; $display("FAIL reset_wr_data got %h want 0000", wr_data); end
      checks++; if (flags !== 4'h0) begin errors++; $display("FAIL reset_flags got %b want 0000", flags); end
      reset = 1'b1; exp_flags = '0;
      @(negedge clock);
   endtask

   task automatic test_add;
      int lat, wc, dc; logic [3:0] ws, fl; logic [15:0] wd; logic il; bit tmo;
      load_reg(1, 16'h7FFF); load_reg(2, 16'h0001);
      issue(16'h0312, lat, wc, dc, ws, wd, il, fl, tmo);
      checks++; if (tmo || lat != 3) begin errors++; $display("FAIL add_latency got %0d want 3", lat); end
      checks++; if (wc != 1 || dc != 1) begin errors++; $display("FAIL add_pulses got wr=%0d done=%0d want 1 1", wc, dc); end
      checks++; if (ws !== 4'd3 || wd !== 16'h8000) begin errors++; $display("FAIL add_write got r%0d=%h want r3=8000", ws, wd); end
      checks++; if (fl !== 4'b0101) begin errors++; $display("FAIL add_flags got %b want 0101", fl); end
      exp_rf[3] = 16'h8000; exp_flags = 4'b0101;
   endtask

   task automatic test_cmp;
      int lat, wc, dc; logic [3:0] ws, fl; logic [15:0] wd; logic il; bit tmo;
      load_reg(4, 16'h1234);
      issue(16'hA544, lat, wc, dc, ws, wd, il, fl, tmo);
      checks++; if (tmo || wc != 0 || dc != 1) begin errors++; $display("FAIL cmp_pulses got wr=%0d done=%0d want 0 1", wc, dc); end
      checks++; if (fl !== 4'b1000 || il !== 1'b0) begin errors++; $display("FAIL cmp_flags got %b ill=%b want 1000 0", fl, il); end
      exp_flags = 4'b1000;
   endtask

   task automatic test_shift;
      int lat, wc, dc; logic [3:0] ws, fl; logic [15:0] wd; logic il; bit tmo;
      load_reg(6, 16'h8001);
      issue(16'h6760, lat, wc, dc, ws, wd, il, fl, tmo);
      checks++; if (tmo || wc != 1 || ws !== 4'd7 || wd !== 16'h0002) begin errors++;
         $display("FAIL shl_write got r%0d=%h wr=%0d want r7=0002", ws, wd, wc); end
      checks++; if (fl !== 4'b0010) begin errors++; $display("FAIL shl_flags got %b want 0010", fl); end
      load_reg(8, 16'h0003);
      issue(16'h7980, lat, wc, dc, ws, wd, il, fl, tmo);
      checks++; if (tmo || wc != 1 || ws !== 4'd9 || wd !== 16'h0001) begin errors++;
         $display("FAIL shr_write got r%0d=%h wr=%0d want r9=0001", ws, wd, wc); end
      checks++; if (fl !== 4'b0010) begin errors++; $display("FAIL shr_flags got %b want 0010", fl); end
      exp_rf[7] = 16'h0002; exp_rf[9] = 16'h0001; exp_flags = 4'b0010;
   endtask

   // Illegal opcode with instr_valid held high: two back-to-back accepts 4 cycles apart.
   task automatic test_illegal_held;
      int acc [2]; int nacc, dn, il, mism, wrs, flbad;
      nacc = 0; dn = 0; il = 0; mism = 0; wrs = 0; flbad = 0; acc[0] = 0; acc[1] = 0;
      instr_valid = 1'b1;
      for (int cyc = 0; cyc < 14; cyc++) begin
         if (cyc > 0) @(negedge clock);
         if (done) dn++;
         if (illegal) il++;
         if (done !== illegal) mism++;
         if (wr) wrs++;
         if (flags !== exp_flags) flbad++;
         instr = instr_ready ? 16'hF123 : {4'h0, 12'($urandom)};
         if (nacc == 2 && !instr_ready) instr_valid = 1'b0;
         if (nacc < 2 && instr_ready && instr_valid) begin acc[nacc] = cyc; nacc++; end
      end
      instr_valid = 1'b0;
      checks++; if (nacc != 2 || acc[1] - acc[0] != 4) begin errors++;
         $display("FAIL ill_throughput got accepts=%0d gap=%0d want 2 4", nacc, acc[1] - acc[0]); end
      checks++; if (dn != 2 || il != 2 || mism != 0) begin errors++;
         $display("FAIL ill_pulses got done=%0d ill=%0d apart=%0d want 2 2 0", dn, il, mism); end
      checks++; if (wrs != 0 || flbad != 0) begin errors++;
         $display("FAIL ill_side_effects got wr=%0d flag_changes=%0d want 0 0", wrs, flbad); end
   endtask

   task automatic test_reset_mid;
      int wrs, dns;
      wrs = 0; dns = 0;
      load_reg(1, 16'h1111); load_reg(2, 16'h2222);
      instr = 16'h0312; instr_valid = 1'b1;
      @(negedge clock); instr_valid = 1'b0;      // READ
      if (wr) wrs++;
      @(negedge clock);                           // EXEC
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_mid_busy got %b want 1", busy); end
      reset = 1'b0;
      @(negedge clock);
      checks++; if ({instr_ready, busy, wr, done, illegal} !== 5'b10000) begin errors++;
         $display("FAIL rst_mid_ctrl got %b want 10000", {instr_ready, busy, wr, done, illegal}); end
      checks++; if ({a_sel, b_sel, wr_sel} !== 12'h000 || wr_data !== 16'h0 || flags !== 4'h0) begin errors++;
         $display("FAIL rst_mid_outs got sel=%h data=%h flags=%b want 000 0000 0000", {a_sel, b_sel, wr_sel}, wr_data, flags); end
      reset = 1'b1;
      repeat (8) begin @(negedge clock); if (wr) wrs++; if (done) dns++; end
      checks++; if (wrs != 0 || dns != 0) begin errors++; $display("FAIL rst_mid_abandon got wr=%0d done=%0d want 0 0", wrs, dns); end
      exp_flags = '0;
   endtask

   task automatic test_mul;
      int lat, wc, dc; logic [3:0] ws, fl; logic [15:0] wd; logic il; bit tmo;
      load_reg(10, 16'h0100);
      issue(16'hBBAA, lat, wc, dc, ws, wd, il, fl, tmo);
`ifdef ALU_MUL_EN
      checks++; if (tmo || lat != 19) begin errors++; $display("FAIL mul_latency got %0d want 19", lat); end
      checks++; if (wc != 1 || ws !== 4'd11 || wd !== 16'h0000 || il !== 1'b0) begin errors++;
         $display("FAIL mul_write got r%0d=%h wr=%0d ill=%b want r11=0000 1 0", ws, wd, wc, il); end
      checks++; if (fl !== 4'b1010) begin errors++; $display("FAIL mul_flags got %b want 1010", fl); end
      exp_rf[11] = 16'h0000; exp_flags = 4'b1010;
`else
      checks++; if (tmo || lat != 3 || il !== 1'b1) begin errors++; $display("FAIL mul_illegal got lat=%0d ill=%b want 3 1", lat, il); end
      checks++; if (wc != 0 || fl !== exp_flags) begin errors++; $display("FAIL mul_no_effect got wr=%0d flags=%b want 0 %b", wc, fl, exp_flags); end
`endif
   endtask

   task automatic test_random;
      int lat, wc, dc, elat; logic [3:0] ws, fl, op, rd, ra, rb, efl; logic [15:0] wd, eres;
      logic il; bit tmo, ewr, eill;
      for (int k = 0; k < 16; k++) load_reg(k, 16'($urandom));
      for (int t = 0; t < 40; t++) begin
         op = 4'($urandom_range(0, 15)); rd = 4'($urandom); ra = 4'($urandom); rb = 4'($urandom);
         if (t % 5 == 0) rb = ra;                 // exercise equal operands / zero results
         model(op, exp_rf[ra], exp_rf[rb], exp_flags, eres, efl, ewr, eill);
         elat = 3;
`ifdef ALU_MUL_EN
         if (op == 4'hB) elat = 19;
`endif
         issue({op, rd, ra, rb}, lat, wc, dc, ws, wd, il, fl, tmo);
         checks++; if (tmo || lat != elat || dc != 1) begin errors++;
            $display("FAIL rnd_timing op=%h got lat=%0d done=%0d want %0d 1", op, lat, dc, elat); end
         checks++; if (wc != (ewr ? 1 : 0) || il !== eill) begin errors++;
            $display("FAIL rnd_ctrl op=%h got wr=%0d ill=%b want %0d %b", op, wc, il, ewr, eill); end
         checks++; if (fl !== efl) begin errors++;
            $display("FAIL rnd_flags op=%h a=%h b=%h got %b want %b", op, exp_rf[ra], exp_rf[rb], fl, efl); end
         if (ewr) begin
            checks++; if (ws !== rd || wd !== eres) begin errors++;
               $display("FAIL rnd_write op=%h a=%h b=%h got r%0d=%h want r%0d=%h", op, exp_rf[ra], exp_rf[rb], ws, wd, rd, eres); end
            exp_rf[rd] = eres;
         end
         exp_flags = efl;
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      @(negedge clock);
      test_reset();
      test_add();
      test_cmp();
      test_shift();
      test_illegal_held();
      test_reset_mid();
      test_mul();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
